// File: rtl/tcm_mem_pkg.sv
// -----------------------------------------------------------------------------
// tcm_mem_pkg
// Shared types and constants for the tightly-coupled memory arbiter:
//   arb_state_e   - data/external port arbiter state
//   TAG_W         - data-port request tag width
//   DATA_W/STRB_W - 32-bit access width and its byte-strobe width
//   WORD_W        - RAM word width (one 64-bit instruction pair)
//   addr_in_range - TCM window decode shared by fetch and data paths
// -----------------------------------------------------------------------------
package tcm_mem_pkg;

    localparam int TAG_W       = 11;
    localparam int DATA_W      = 32;
    localparam int STRB_W      = 4;
    localparam int WORD_W      = 64;
    localparam int WORD_STRB_W = 8;

    typedef enum logic {
        CPU_PRI   = 1'b0,
        EXT_GRANT = 1'b1
    } arb_state_e;

    // The TCM occupies one naturally aligned window; everything above the
    // byte offset inside a 64-bit word array must match the base address.
    function automatic logic addr_in_range(input logic [31:0] addr,
                                           input logic [31:0] base,
                                           input int          ram_addr_w);
        return (addr >> (ram_addr_w + 3)) == (base >> (ram_addr_w + 3));
    endfunction

endpackage

// File: rtl/tcm_mem_ram_p.sv
// -----------------------------------------------------------------------------
// tcm_mem_ram_p
// Parametrised true dual-port 64-bit RAM, read-first on both ports.
//   clk_i     - clock
//   addr0_i   - port 0 (fetch) word address, read only
//   rdata0_o  - port 0 registered read data
//   addr1_i   - port 1 (data/external) word address
//   wstrb1_i  - port 1 byte-write enables, one per byte of the 64-bit word
//   wdata1_i  - port 1 write data
//   rdata1_o  - port 1 registered read data (old contents on a write)
// -----------------------------------------------------------------------------
module tcm_mem_ram_p
    import tcm_mem_pkg::*;
#(
    parameter int ADDR_W = 13
) (
    input  logic                   clk_i,
    input  logic [ADDR_W-1:0]      addr0_i,
    output logic [WORD_W-1:0]      rdata0_o,
    input  logic [ADDR_W-1:0]      addr1_i,
    input  logic [WORD_STRB_W-1:0] wstrb1_i,
    input  logic [WORD_W-1:0]      wdata1_i,
    output logic [WORD_W-1:0]      rdata1_o
);

    logic [WORD_W-1:0] mem_q [0:(1 << ADDR_W)-1];

    always_ff @(posedge clk_i) begin
        rdata0_o <= mem_q[addr0_i];
    end

    always_ff @(posedge clk_i) begin
        rdata1_o <= mem_q[addr1_i];
        for (int b = 0; b < WORD_STRB_W; b++) begin
            if (wstrb1_i[b]) begin
                mem_q[addr1_i][b*8 +: 8] <= wdata1_i[b*8 +: 8];
            end
        end
    end

endmodule

// File: rtl/tcm_mem_arb.sv
// -----------------------------------------------------------------------------
// tcm_mem_arb
// TCM with an always-ready instruction fetch port and a shared data port
// arbitrated between the CPU data interface and an external master.
//   clk_i / rst_i          - clock, asynchronous active-low reset
//   mem_i_*                - fetch: request/pc in, valid/error/64-bit inst out
//   mem_d_*                - CPU data: rd, byte strobes, addr, wdata, tag in;
//                            accept, ack, error, rdata, response tag out
//   ext_*                  - external master: rd, byte strobes, addr, wdata in;
//                            accept, ack, error, rdata out
// The CPU has priority; an external master that keeps losing for
// FAIR_LIMIT cycles is given one forced grant cycle.
// -----------------------------------------------------------------------------
module tcm_mem_arb
    import tcm_mem_pkg::*;
#(
    parameter int          RAM_ADDR_W = 13,
    parameter logic [31:0] BASE_ADDR  = 32'h0,
    parameter int          FAIR_LIMIT = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              mem_i_rd_i,
    input  logic [31:0]       mem_i_pc_i,
    output logic              mem_i_valid_o,
    output logic              mem_i_error_o,
    output logic [WORD_W-1:0] mem_i_inst_o,
    input  logic              mem_d_rd_i,
    input  logic [STRB_W-1:0] mem_d_wr_i,
    input  logic [31:0]       mem_d_addr_i,
    input  logic [DATA_W-1:0] mem_d_data_wr_i,
    input  logic [TAG_W-1:0]  mem_d_req_tag_i,
    output logic              mem_d_accept_o,
    output logic              mem_d_ack_o,
    output logic              mem_d_error_o,
    output logic [DATA_W-1:0] mem_d_data_rd_o,
    output logic [TAG_W-1:0]  mem_d_resp_tag_o,
    input  logic              ext_rd_i,
    input  logic [STRB_W-1:0] ext_wr_i,
    input  logic [31:0]       ext_addr_i,
    input  logic [DATA_W-1:0] ext_data_wr_i,
    output logic              ext_accept_o,
    output logic              ext_ack_o,
    output logic              ext_error_o,
    output logic [DATA_W-1:0] ext_data_rd_o
);

    localparam logic [3:0] FAIR_LIM = 4'(FAIR_LIMIT);

    arb_state_e             state_q;
    logic [3:0]             starve_q, starve_d;
    logic                   d_req, e_req, d_fire, e_fire;
    logic [31:0]            p1_addr;
    logic [STRB_W-1:0]      p1_strb;
    logic [DATA_W-1:0]      p1_wdata;
    logic                   p1_in_range, p1_lane;
    logic [WORD_STRB_W-1:0] ram_wstrb;
    logic [WORD_W-1:0]      ram_rdata0, ram_rdata1;

    logic                   i_valid_q, i_err_q;
    logic                   d_ack_q, d_err_q, d_lane_q;
    logic [TAG_W-1:0]       d_tag_q;
    logic [DATA_W-1:0]      d_data_q, d_data_now;
    logic                   e_ack_q, e_err_q, e_lane_q;
    logic [DATA_W-1:0]      e_data_q, e_data_now;

    // ---------------- arbitration ----------------
    assign d_req          = mem_d_rd_i || (|mem_d_wr_i);
    assign e_req          = ext_rd_i || (|ext_wr_i);
    assign mem_d_accept_o = (state_q != EXT_GRANT);
    assign ext_accept_o   = (state_q == EXT_GRANT) || !d_req;
    // The two accepts are never both taken, so at most one fire per cycle.
    assign d_fire         = d_req && mem_d_accept_o;
    assign e_fire         = e_req && ext_accept_o;

    // The forced-grant cycle counts as an external grant even if the
    // external master has gone idle, so the counter cannot re-trigger.
    always_comb begin
        starve_d = starve_q;
        if ((state_q == EXT_GRANT) || e_fire) begin
            starve_d = '0;
        end else if (e_req && d_fire && (starve_q < FAIR_LIM)) begin
            starve_d = starve_q + 4'd1;
        end
    end

    // ---------------- shared RAM port ----------------
    assign p1_addr     = e_fire ? ext_addr_i    : mem_d_addr_i;
    assign p1_wdata    = e_fire ? ext_data_wr_i : mem_d_data_wr_i;
    assign p1_strb     = e_fire ? ext_wr_i : (d_fire ? mem_d_wr_i : '0);
    assign p1_in_range = addr_in_range(p1_addr, BASE_ADDR, RAM_ADDR_W);
    assign p1_lane     = p1_addr[2];

    // Steer the 4 strobes onto the addressed 32-bit half of the 64-bit word.
    generate
        for (genvar gi = 0; gi < WORD_STRB_W; gi++) begin : g_wstrb
            assign ram_wstrb[gi] = p1_in_range && (p1_lane == 1'(gi / STRB_W))
                                   && p1_strb[gi % STRB_W];
        end
    endgenerate

    tcm_mem_ram_p #(
        .ADDR_W (RAM_ADDR_W)
    ) u_ram (
        .clk_i    (clk_i),
        .addr0_i  (mem_i_pc_i[RAM_ADDR_W+2:3]),
        .rdata0_o (ram_rdata0),
        .addr1_i  (p1_addr[RAM_ADDR_W+2:3]),
        .wstrb1_i (ram_wstrb),
        .wdata1_i ({p1_wdata, p1_wdata}),
        .rdata1_o (ram_rdata1)
    );

    // ---------------- state and response registers ----------------
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= CPU_PRI;
            starve_q  <= '0;
            i_valid_q <= 1'b0;
            i_err_q   <= 1'b0;
            d_ack_q   <= 1'b0;
            d_err_q   <= 1'b0;
            d_lane_q  <= 1'b0;
            d_tag_q   <= '0;
            d_data_q  <= '0;
            e_ack_q   <= 1'b0;
            e_err_q   <= 1'b0;
            e_lane_q  <= 1'b0;
            e_data_q  <= '0;
        end else begin
            starve_q <= starve_d;
            case (state_q)
                CPU_PRI:   if (starve_d == FAIR_LIM) state_q <= EXT_GRANT;
                EXT_GRANT: state_q <= CPU_PRI;
                default:   state_q <= CPU_PRI;
            endcase

            i_valid_q <= mem_i_rd_i;
            i_err_q   <= mem_i_rd_i && !addr_in_range(mem_i_pc_i, BASE_ADDR, RAM_ADDR_W);

            d_ack_q <= d_fire;
            d_err_q <= d_fire && !p1_in_range;
            if (d_fire) begin
                d_lane_q <= p1_lane;
                d_tag_q  <= mem_d_req_tag_i;
            end

            e_ack_q <= e_fire;
            e_err_q <= e_fire && !p1_in_range;
            if (e_fire) e_lane_q <= p1_lane;

            // Remember the last delivered value so the outputs hold between acks.
            if (d_ack_q) d_data_q <= d_data_now;
            if (e_ack_q) e_data_q <= e_data_now;
        end
    end

    assign d_data_now = d_err_q ? '0 : (d_lane_q ? ram_rdata1[63:32] : ram_rdata1[31:0]);
    assign e_data_now = e_err_q ? '0 : (e_lane_q ? ram_rdata1[63:32] : ram_rdata1[31:0]);

    assign mem_i_valid_o    = i_valid_q;
    assign mem_i_error_o    = i_err_q;
    assign mem_i_inst_o     = (i_valid_q && !i_err_q) ? ram_rdata0 : '0;
    assign mem_d_ack_o      = d_ack_q;
    assign mem_d_error_o    = d_err_q;
    assign mem_d_data_rd_o  = d_ack_q ? d_data_now : d_data_q;
    assign mem_d_resp_tag_o = d_tag_q;
    assign ext_ack_o        = e_ack_q;
    assign ext_error_o      = e_err_q;
    assign ext_data_rd_o    = e_ack_q ? e_data_now : e_data_q;

endmodule

// File: tb/tb_tcm_mem_arb.sv
// -----------------------------------------------------------------------------
// tb_tcm_mem_arb
// Self-checking bench for tcm_mem_arb: a table of data-port transactions,
// hand-written fairness / read-first / reset sequences, and randomized
// traffic on all three ports against a byte-level memory model.
// -----------------------------------------------------------------------------
module tb_tcm_mem_arb;

    localparam int          AW   = 13;
    localparam logic [31:0] BASE = 32'h0002_0000;
    localparam int          FL   = 4;
    localparam logic [31:0] SPAN = 32'h1 << (AW + 3);

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        mem_i_rd_i;
    logic [31:0] mem_i_pc_i;
    logic        mem_i_valid_o, mem_i_error_o;
    logic [63:0] mem_i_inst_o;
    logic        mem_d_rd_i;
    logic [3:0]  mem_d_wr_i;
    logic [31:0] mem_d_addr_i, mem_d_data_wr_i;
    logic [10:0] mem_d_req_tag_i;
    logic        mem_d_accept_o, mem_d_ack_o, mem_d_error_o;
    logic [31:0] mem_d_data_rd_o;
    logic [10:0] mem_d_resp_tag_o;
    logic        ext_rd_i;
    logic [3:0]  ext_wr_i;
    logic [31:0] ext_addr_i, ext_data_wr_i;
    logic        ext_accept_o, ext_ack_o, ext_error_o;
    logic [31:0] ext_data_rd_o;

    always #5 clk_i = ~clk_i;

    tcm_mem_arb #(
        .RAM_ADDR_W (AW),
        .BASE_ADDR  (BASE),
        .FAIR_LIMIT (FL)
    ) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .mem_i_rd_i       (mem_i_rd_i),
        .mem_i_pc_i       (mem_i_pc_i),
        .mem_i_valid_o    (mem_i_valid_o),
        .mem_i_error_o    (mem_i_error_o),
        .mem_i_inst_o     (mem_i_inst_o),
        .mem_d_rd_i       (mem_d_rd_i),
        .mem_d_wr_i       (mem_d_wr_i),
        .mem_d_addr_i     (mem_d_addr_i),
        .mem_d_data_wr_i  (mem_d_data_wr_i),
        .mem_d_req_tag_i  (mem_d_req_tag_i),
        .mem_d_accept_o   (mem_d_accept_o),
        .mem_d_ack_o      (mem_d_ack_o),
        .mem_d_error_o    (mem_d_error_o),
        .mem_d_data_rd_o  (mem_d_data_rd_o),
        .mem_d_resp_tag_o (mem_d_resp_tag_o),
        .ext_rd_i         (ext_rd_i),
        .ext_wr_i         (ext_wr_i),
        .ext_addr_i       (ext_addr_i),
        .ext_data_wr_i    (ext_data_wr_i),
        .ext_accept_o     (ext_accept_o),
        .ext_ack_o        (ext_ack_o),
        .ext_error_o      (ext_error_o),
        .ext_data_rd_o    (ext_data_rd_o)
    );

    typedef struct packed {
        logic        i_rd;
        logic [31:0] pc;
        logic        d_rd;
        logic [3:0]  d_wr;
        logic [31:0] d_addr;
        logic [31:0] d_wdata;
        logic [10:0] tag;
        logic        e_rd;
        logic [3:0]  e_wr;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
    } stim_t;

    typedef struct packed {
        logic        i_v, i_e, i_k;
        logic [63:0] i_data;
        logic        d_ack, d_err, d_k;
        logic [10:0] d_tag;
        logic [31:0] d_data;
        logic        e_ack, e_err, e_k;
        logic [31:0] e_data;
    } resp_t;

    typedef struct packed {
        logic        rd;
        logic [3:0]  wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [10:0] tag;
        logic        exp_err;
        logic [31:0] exp_data;
    } vec_t;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state: memory as bytes keyed by offset from BASE.
    logic [7:0]  mb [int];
    resp_t       pend;
    logic [31:0] last_d, last_e;
    logic        last_d_k, last_e_k;
    int          lost;
    logic        forced;
    logic        obs_dacc, obs_eacc;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic inr(input logic [31:0] a);
        longint unsigned ua = a;
        longint unsigned lb = BASE;
        longint unsigned ls = SPAN;
        return (ua >= lb) && (ua < lb + ls);
    endfunction

    function automatic void m_rd32(input logic [31:0] a, output logic [31:0] v, output logic k);
        int o = int'(a - BASE) & -4;
        v = '0;
        k = 1'b1;
        for (int b = 0; b < 4; b++) begin
            if (mb.exists(o + b)) v[b*8 +: 8] = mb[o + b];
            else k = 1'b0;
        end
    endfunction

    function automatic void m_rd64(input logic [31:0] a, output logic [63:0] v, output logic k);
        int o = int'(a - BASE) & -8;
        v = '0;
        k = 1'b1;
        for (int b = 0; b < 8; b++) begin
            if (mb.exists(o + b)) v[b*8 +: 8] = mb[o + b];
            else k = 1'b0;
        end
    endfunction

    function automatic void m_wr(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
        int o = int'(a - BASE) & -4;
        if (inr(a)) begin
            for (int b = 0; b < 4; b++) if (s[b]) mb[o + b] = d[b*8 +: 8];
        end
    endfunction

    function automatic void model_reset();
        pend     = '0;
        last_d   = '0;
        last_e   = '0;
        last_d_k = 1'b1;
        last_e_k = 1'b1;
        lost     = 0;
        forced   = 1'b0;
    endfunction

    task automatic drive(input stim_t s);
        mem_i_rd_i      = s.i_rd;
        mem_i_pc_i      = s.pc;
        mem_d_rd_i      = s.d_rd;
        mem_d_wr_i      = s.d_wr;
        mem_d_addr_i    = s.d_addr;
        mem_d_data_wr_i = s.d_wdata;
        mem_d_req_tag_i = s.tag;
        ext_rd_i        = s.e_rd;
        ext_wr_i        = s.e_wr;
        ext_addr_i      = s.e_addr;
        ext_data_wr_i   = s.e_wdata;
    endtask

    // Called at posedge+1: applies one cycle of stimulus, checks the
    // responses from the previous cycle, and returns at the next posedge+1.
    task automatic run_cycle(input stim_t s);
        resp_t np;
        logic  dq, eq, dacc, eacc, df, ef;
        drive(s);
        #1;
        chk("i_valid", mem_i_valid_o, pend.i_v);
        if (pend.i_v) begin
            chk("i_error", mem_i_error_o, pend.i_e);
            if (pend.i_k) chk("i_inst", mem_i_inst_o, pend.i_data);
        end
        chk("d_ack", mem_d_ack_o, pend.d_ack);
        if (pend.d_ack) begin
            chk("d_error", mem_d_error_o, pend.d_err);
            chk("d_tag", mem_d_resp_tag_o, pend.d_tag);
            if (pend.d_k) chk("d_data", mem_d_data_rd_o, pend.d_data);
            last_d   = pend.d_data;
            last_d_k = pend.d_k;
        end else if (last_d_k) begin
            chk("d_hold", mem_d_data_rd_o, last_d);
        end
        chk("e_ack", ext_ack_o, pend.e_ack);
        if (pend.e_ack) begin
            chk("e_error", ext_error_o, pend.e_err);
            if (pend.e_k) chk("e_data", ext_data_rd_o, pend.e_data);
            last_e   = pend.e_data;
            last_e_k = pend.e_k;
        end else if (last_e_k) begin
            chk("e_hold", ext_data_rd_o, last_e);
        end

        dq   = s.d_rd || (s.d_wr != 4'b0);
        eq   = s.e_rd || (s.e_wr != 4'b0);
        dacc = !forced;
        eacc = forced || !dq;
        obs_dacc = mem_d_accept_o;
        obs_eacc = ext_accept_o;
        chk("d_accept", obs_dacc, dacc);
        chk("e_accept", obs_eacc, eacc);
        df = dq && dacc;
        ef = eq && eacc;

        np       = '0;
        np.i_v   = s.i_rd;
        np.i_e   = s.i_rd && !inr(s.pc);
        np.i_k   = 1'b1;
        if (s.i_rd && inr(s.pc)) m_rd64(s.pc, np.i_data, np.i_k);
        np.d_ack = df;
        np.d_err = df && !inr(s.d_addr);
        np.d_tag = s.tag;
        np.d_k   = 1'b1;
        if (df && inr(s.d_addr)) m_rd32(s.d_addr, np.d_data, np.d_k);
        np.e_ack = ef;
        np.e_err = ef && !inr(s.e_addr);
        np.e_k   = 1'b1;
        if (ef && inr(s.e_addr)) m_rd32(s.e_addr, np.e_data, np.e_k);

        // Writes land after every read of this cycle has seen the old data.
        if (df) m_wr(s.d_addr, s.d_wr, s.d_wdata);
        if (ef) m_wr(s.e_addr, s.e_wr, s.e_wdata);

        if (forced) begin
            forced = 1'b0;
            lost   = 0;
        end else if (ef) begin
            lost = 0;
        end else if (eq && df) begin
            lost++;
            if (lost == FL) forced = 1'b1;
        end
        pend = np;
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_reset_outs(input string nm);
        chk({nm, "_i_valid"}, mem_i_valid_o, 0);
        chk({nm, "_i_error"}, mem_i_error_o, 0);
        chk({nm, "_i_inst"},  mem_i_inst_o, 0);
        chk({nm, "_d_ack"},   mem_d_ack_o, 0);
        chk({nm, "_d_error"}, mem_d_error_o, 0);
        chk({nm, "_d_data"},  mem_d_data_rd_o, 0);
        chk({nm, "_d_tag"},   mem_d_resp_tag_o, 0);
        chk({nm, "_e_ack"},   ext_ack_o, 0);
        chk({nm, "_e_error"}, ext_error_o, 0);
        chk({nm, "_e_data"},  ext_data_rd_o, 0);
    endtask

    function automatic logic [31:0] rand_addr();
        int r = $urandom_range(0, 9);
        if (r == 0) return BASE + SPAN + 32'($urandom_range(0, 63) << 2);
        if (r == 1) return BASE - 32'd4 - 32'($urandom_range(0, 15) << 2);
        return BASE + 32'h800 + 32'($urandom_range(0, 127));
    endfunction

    function automatic vec_t mk(input logic rd, input logic [3:0] wr, input logic [31:0] addr,
                                input logic [31:0] wd, input logic [10:0] tag,
                                input logic err, input logic [31:0] exp);
        vec_t v;
        v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wd;
        v.tag = tag; v.exp_err = err; v.exp_data = exp;
        return v;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        vec_t  tbl [12];
        stim_t s;
        stim_t idle;

        tbl[0]  = mk(0, 4'hF,    BASE + 32'h104, 32'hDEADBEEF, 11'h011, 0, 32'h0);
        tbl[1]  = mk(1, 4'h0,    BASE + 32'h104, 32'h0,        11'h7A5, 0, 32'hDEADBEEF);
        tbl[2]  = mk(0, 4'hF,    BASE + 32'h200, 32'h11223344, 11'h002, 0, 32'h0);
        tbl[3]  = mk(0, 4'b0010, BASE + 32'h200, 32'h0000AA00, 11'h003, 0, 32'h0);
        tbl[4]  = mk(1, 4'h0,    BASE + 32'h200, 32'h0,        11'h004, 0, 32'h1122AA44);
        tbl[5]  = mk(0, 4'hF,    BASE + 32'h0,   32'hCAFEF00D, 11'h005, 0, 32'h0);
        tbl[6]  = mk(0, 4'hF,    BASE + SPAN,    32'h55555555, 11'h006, 1, 32'h0);
        tbl[7]  = mk(1, 4'h0,    BASE + SPAN,    32'h0,        11'h400, 1, 32'h0);
        tbl[8]  = mk(1, 4'h0,    BASE + 32'h0,   32'h0,        11'h008, 0, 32'hCAFEF00D);
        tbl[9]  = mk(0, 4'hF,    BASE + 32'h100, 32'h12345678, 11'h009, 0, 32'h0);
        tbl[10] = mk(1, 4'h0,    BASE + 32'h104, 32'h0,        11'h00A, 0, 32'hDEADBEEF);
        tbl[11] = mk(1, 4'h0,    BASE - 32'd4,   32'h0,        11'h00B, 1, 32'h0);

        idle = '0;
        rst_i = 1'b0;
        drive(idle);
        model_reset();

        // Reset state
        repeat (3) @(posedge clk_i);
        #1;
        check_reset_outs("reset");
        rst_i = 1'b1;

        // Table of single data-port transactions, each followed by an idle cycle
        for (int i = 0; i < 12; i++) begin
            s         = idle;
            s.d_rd    = tbl[i].rd;
            s.d_wr    = tbl[i].wr;
            s.d_addr  = tbl[i].addr;
            s.d_wdata = tbl[i].wdata;
            s.tag     = tbl[i].tag;
            run_cycle(s);
            chk("tbl_ack", mem_d_ack_o, 1);
            chk("tbl_err", mem_d_error_o, tbl[i].exp_err);
            chk("tbl_tag", mem_d_resp_tag_o, tbl[i].tag);
            if (tbl[i].rd) chk("tbl_data", mem_d_data_rd_o, tbl[i].exp_data);
            $display("vec %0d: addr=%h rd=%0d wr=%h data=%h err=%0d", i, tbl[i].addr,
                     tbl[i].rd, tbl[i].wr, mem_d_data_rd_o, mem_d_error_o);
            run_cycle(idle);
        end

        // Fairness: data and external both requesting every cycle
        for (int k = 1; k <= 10; k++) begin
            s        = idle;
            s.d_rd   = 1'b1;
            s.d_addr = BASE + 32'h104;
            s.tag    = 11'(k);
            s.e_rd   = 1'b1;
            s.e_addr = BASE + 32'h200;
            run_cycle(s);
            chk("fair_e_accept", obs_eacc, (k % 5) == 0);
            chk("fair_d_accept", obs_dacc, (k % 5) != 0);
            $display("fair cycle %0d: d_accept=%0d ext_accept=%0d", k, obs_dacc, obs_eacc);
        end
        run_cycle(idle);

        // Read-first: fetch and write of the same word in one cycle
        s = idle; s.d_wr = 4'hF; s.d_addr = BASE + 32'h300; s.d_wdata = 32'h33334444;
        run_cycle(s);
        s = idle; s.d_wr = 4'hF; s.d_addr = BASE + 32'h304; s.d_wdata = 32'h11112222;
        run_cycle(s);
        s = idle; s.i_rd = 1'b1; s.pc = BASE + 32'h300;
        s.d_wr = 4'hF; s.d_addr = BASE + 32'h304; s.d_wdata = 32'hAAAAAAAA;
        run_cycle(s);
        chk("rf_old_valid", mem_i_valid_o, 1);
        chk("rf_old_inst", mem_i_inst_o, 64'h11112222_33334444);
        s = idle; s.i_rd = 1'b1; s.pc = BASE + 32'h300;
        run_cycle(s);
        chk("rf_new_inst", mem_i_inst_o, 64'hAAAAAAAA_33334444);
        $display("read-first: second fetch inst=%h", mem_i_inst_o);
        run_cycle(idle);

        // Randomized traffic: fill a window first, then mix all three ports
        for (int w = 0; w < 32; w++) begin
            s = idle; s.e_wr = 4'hF; s.e_addr = BASE + 32'h800 + 32'(w * 4); s.e_wdata = $urandom;
            run_cycle(s);
        end
        for (int c = 0; c < 400; c++) begin
            int r;
            s = idle;
            s.i_rd = 1'($urandom_range(0, 1));
            s.pc   = rand_addr();
            r = $urandom_range(0, 9);
            if (r >= 7) s.d_wr = 4'($urandom_range(1, 15));
            else if (r >= 4) s.d_rd = 1'b1;
            s.d_addr  = rand_addr();
            s.d_wdata = $urandom;
            s.tag     = 11'($urandom);
            r = $urandom_range(0, 3);
            if (r == 3) s.e_wr = 4'($urandom_range(1, 15));
            else if (r == 2) s.e_rd = 1'b1;
            s.e_addr  = rand_addr();
            s.e_wdata = $urandom;
            run_cycle(s);
        end
        run_cycle(idle);

        // Reset asserted the cycle after an accepted read: the ack is dropped
        s = idle; s.d_rd = 1'b1; s.d_addr = BASE + 32'h104; s.tag = 11'h155;
        drive(s);
        #1;
        chk("rst_accept", mem_d_accept_o, 1);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        drive(idle);
        #1;
        check_reset_outs("midrst");
        repeat (2) begin
            @(posedge clk_i);
            #1;
            check_reset_outs("midrst_hold");
        end
        @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        model_reset();
        repeat (3) run_cycle(idle);
        $display("reset release: no stale ack, d_ack=%0d", mem_d_ack_o);

        // RAM contents survive reset
        s = idle; s.d_rd = 1'b1; s.d_addr = BASE + 32'h104; s.tag = 11'h2AA;
        run_cycle(s);
        chk("post_rst_data", mem_d_data_rd_o, 32'hDEADBEEF);
        run_cycle(idle);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/tcm_mem_arb.md
TCM_MEM_ARB -- requirements
Module: tcm_mem_arb

Interface
REQ-001 The block SHALL have parameter RAM_ADDR_W, default 13, meaning the 64-bit word-address width (depth = 2^RAM_ADDR_W words).
REQ-002 The block SHALL have parameter BASE_ADDR, default 32'h0, meaning the TCM base address, aligned to the TCM size.
REQ-003 The block SHALL have parameter FAIR_LIMIT, default 4, meaning the number of consecutive external-blocked cycles before a forced external grant (range 1..15).
REQ-004 Ports SHALL be, one per line: name, direction, width, meaning.
- clk_i  in  1  single clock.
- rst_i  in  1  reset, asynchronous, active-low.
- mem_i_rd_i  in  1  fetch request.
- mem_i_pc_i  in  32  fetch address.
- mem_i_valid_o  out  1  fetch data valid.
- mem_i_error_o  out  1  fetch out of range.
- mem_i_inst_o  out  64  fetch data.
- mem_d_rd_i  in  1  data read.
- mem_d_wr_i  in  4  data byte-write strobes.
- mem_d_addr_i  in  32  data address.
- mem_d_data_wr_i  in  32  write data.
- mem_d_req_tag_i  in  11  request tag.
- mem_d_accept_o  out  1  data request accepted.
- mem_d_ack_o  out  1  data response.
- mem_d_error_o  out  1  data out of range.
- mem_d_data_rd_o  out  32  read data.
- mem_d_resp_tag_o  out  11  response tag.
- ext_rd_i  in  1  external read.
- ext_wr_i  in  4  external byte-write strobes.
- ext_addr_i  in  32  external address.
- ext_data_wr_i  in  32  external write data.
- ext_accept_o  out  1  external request accepted.
- ext_ack_o  out  1  external response.
- ext_error_o  out  1  external out of range.
- ext_data_rd_o  out  32  external read data.

Function
REQ-005 A request SHALL be in range iff addr[31:RAM_ADDR_W+3] equals BASE_ADDR[31:RAM_ADDR_W+3]; word index = addr[RAM_ADDR_W+2:3]; lane = addr[2].
REQ-006 The fetch port SHALL always accept; mem_i_valid_o SHALL assert exactly 1 cycle after mem_i_rd_i, with mem_i_inst_o holding that word, and mem_i_error_o set in the same cycle if out of range.
REQ-007 The data/ext arbiter SHALL have states CPU_PRI and EXT_GRANT; in CPU_PRI a data request wins, and ext is granted only when no data request is present.
REQ-008 starve_q SHALL increment each cycle ext requests while data wins, clear on any ext grant, and saturate at FAIR_LIMIT.
REQ-009 When starve_q equals FAIR_LIMIT, the next cycle SHALL be EXT_GRANT, in which mem_d_accept_o is 0 and ext_accept_o is 1 regardless of data requests; the arbiter SHALL return to CPU_PRI after one cycle.
REQ-010 ext_accept_o SHALL be combinational: 1 in EXT_GRANT, or in CPU_PRI with no data request; mem_d_accept_o SHALL be 1 except in EXT_GRANT.
REQ-011 An accepted request SHALL produce its ack exactly 1 cycle later, with read data from the latched lane, the tag (data port only), and the error flag.
REQ-012 An out-of-range write SHALL not modify RAM; out-of-range read data SHALL be 0.
REQ-013 A write SHALL update only the byte lanes selected by its strobes in the addressed 32-bit half.
REQ-014 A fetch and a data/ext write to the same word in the same cycle SHALL return old data to the fetch (read-first).
REQ-015 mem_d_data_rd_o and ext_data_rd_o SHALL hold their last value when no ack is present.
REQ-016 Back-to-back accepted requests SHALL sustain one ack per cycle with no bubbles.

Reset
REQ-017 While rst_i is 0, the following SHALL be held: state=CPU_PRI, starve_q=0, all valid/ack/error outputs 0, tags 0, data outputs 0; RAM contents are not reset.
REQ-018 A reset asserted mid-operation SHALL drop any pending ack; no response SHALL be issued after reset release for pre-reset requests.

Structure
REQ-019 Package tcm_mem_pkg SHALL hold the arbiter-state enum, tag width (11), and data/strobe width constants.
REQ-020 Sub-module tcm_mem_ram_p SHALL be a parametrised true dual-port 64-bit RAM (port 0 read-only fetch, port 1 byte-write), instantiated once.

Verification
REQ-021 Write 32'hDEADBEEF to 0x104 with strobes 4'hF, then read 0x104 -> ack after 1 cycle, data 32'hDEADBEEF, tag echoed, error 0.
REQ-022 Write strobe 4'b0010 with data 32'h0000AA00 onto word 0x11223344 -> readback 32'h1122AA44.
REQ-023 Data read continuously while ext_rd_i is held, FAIR_LIMIT=4 -> ext_accept_o is 1 on the 5th cycle, mem_d_accept_o is 0 in that cycle only.
REQ-024 Access at BASE_ADDR + 2^(RAM_ADDR_W+3) -> error 1, read data 0, and a subsequent in-range read shows RAM unchanged.
REQ-025 Fetch and data write to the same word in the same cycle -> mem_i_inst_o shows old data; the next fetch shows new data.
REQ-026 rst_i asserted the cycle after an accept -> no ack; all outputs 0 until release.
